// File: rtl/array_dim_walker_pkg.sv
// Shared types and dimension helpers for the array dimension walker.
package dims_pkg;

    typedef bit [3:0][2:1] packed_reg;

    typedef enum logic {IDLE, STREAM} walker_state_e;

    // Number of elements between two declared bounds, inclusive, either direction.
    function automatic int dim_size(input int l, input int r);
        return (l <= r) ? (r - l + 1) : (l - r + 1);
    endfunction

    // Direction of travel from the $left bound toward the $right bound.
    function automatic int dim_step(input int l, input int r);
        return (l <= r) ? 1 : -1;
    endfunction

endpackage

// File: rtl/array_dim_walker_counter.sv
// One dimension's declared index: starts at $left (or $right when reversed),
// steps toward the other bound, and wraps back to its start bound.
module array_dim_counter
    import dims_pkg::*;
#(
    parameter int L = 0,
    parameter int R = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rev,
    input  logic               start,
    input  logic               advance,
    output logic signed [31:0] idx,
    output logic               at_end
);

    localparam int STEP = dim_step(L, R);

    logic signed [31:0] idx_q, idx_d;
    logic               rev_q, rev_d;

    assign idx    = idx_q;
    assign at_end = (idx_q == (rev_q ? L : R));

    // Next index: load start bound on start, else step or wrap on advance.
    always_comb begin
        rev_d = rev_q;
        idx_d = idx_q;
        if (start) begin
            rev_d = rev;
            idx_d = rev ? R : L;
        end else if (advance) begin
            if (at_end) idx_d = rev_q ? R : L;
            else        idx_d = rev_q ? (idx_q - STEP) : (idx_q + STEP);
        end
    end

    // Index and direction registers; reset parks the index on $left.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= L;
            rev_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            rev_q <= rev_d;
        end
    end

endmodule

// File: rtl/array_dim_walker.sv
// Captures a [L1:R1][L2:R2] array of packed words in one load handshake and
// streams the elements out in declared dimension order with their indices.
module array_dim_walker
    import dims_pkg::*;
#(
    parameter int L1 = 1,
    parameter int R1 = 5,
    parameter int L2 = 2,
    parameter int R2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               load_rev,
    input  packed_reg          load_data [L1:R1][L2:R2],
    output logic               out_valid,
    input  logic               out_ready,
    output packed_reg          out_data,
    output logic signed [31:0] out_idx1,
    output logic signed [31:0] out_idx2,
    output logic               out_first,
    output logic               out_last,
    output logic               busy
);

    localparam int N1 = dim_size(L1, R1);
    localparam int N2 = dim_size(L2, R2);
    localparam int N  = N1 * N2;
    localparam int S1 = dim_step(L1, R1);
    localparam int S2 = dim_step(L2, R2);

    walker_state_e state_q, state_d;
    logic          first_q;
    logic          capture, adv, at_end1, at_end2;

    // Buffer is flattened in walk order; the read mux is a one-hot AND-OR so
    // every index into the buffer is an elaboration-time constant.
    logic [N-1:0][7:0] buf_q, load_flat, masked;
    logic [7:0][N-1:0] col;
    logic [N-1:0]      hit;
    logic [7:0]        rd;

    for (genvar a = 0; a < N1; a++) begin : g_d1
        for (genvar b = 0; b < N2; b++) begin : g_d2
            localparam int I = L1 + a * S1;
            localparam int J = L2 + b * S2;
            localparam int K = a * N2 + b;
            assign load_flat[K] = load_data[I][J];
            assign hit[K]       = (out_idx1 == I) && (out_idx2 == J);
            assign masked[K]    = hit[K] ? buf_q[K] : 8'h00;
        end
    end

    for (genvar bt = 0; bt < 8; bt++) begin : g_bit
        for (genvar k = 0; k < N; k++) begin : g_elem
            assign col[bt][k] = masked[k][bt];
        end
        assign rd[bt] = |col[bt];
    end

    assign load_ready = (state_q == IDLE);
    assign out_valid  = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign out_first  = first_q;
    assign out_last   = out_valid && at_end1 && at_end2;
    assign out_data   = out_valid ? packed_reg'(rd) : packed_reg'(8'h00);
    assign adv        = out_valid && out_ready && !out_last;

    array_dim_counter #(.L(L1), .R(R1)) u_dim1 (
        .clk     (clk),
        .rst     (rst),
        .rev     (load_rev),
        .start   (capture),
        .advance (adv && at_end2),
        .idx     (out_idx1),
        .at_end  (at_end1)
    );

    array_dim_counter #(.L(L2), .R(R2)) u_dim2 (
        .clk     (clk),
        .rst     (rst),
        .rev     (load_rev),
        .start   (capture),
        .advance (adv),
        .idx     (out_idx2),
        .at_end  (at_end2)
    );

    // Walker FSM: accept a load when idle, return to idle after the last beat.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and first-beat flag; the buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture)                     first_q <= 1'b1;
            else if (out_valid && out_ready) first_q <= 1'b0;
        end
    end

    // Array capture on the load handshake.
    always_ff @(posedge clk) begin
        if (capture) buf_q <= load_flat;
    end

endmodule

// File: doc/array_dim_walker.md
Name: array_dim_walker

Overview:
- Downstream consumer of a multidimensional unpacked array of packed words, shaped like `input bit [3:0][2:1] n [1:5][2:8]`.
- Captures the whole array in one load handshake, then streams the elements out one per valid/ready handshake.
- Walk order follows the declared dimension order: dimension 1 is outermost, dimension 2 innermost, each dimension walked from its `$left` bound to its `$right` bound, or the reverse.
- Each output beat carries the element's declared indices, so downstream logic sees the same numbering that `$left`/`$right`/`$low`/`$high` report.

Parameters:
- L1, 1, `$left` bound of unpacked dimension 1
- R1, 5, `$right` bound of unpacked dimension 1
- L2, 2, `$left` bound of unpacked dimension 2
- R2, 8, `$right` bound of unpacked dimension 2
- Element type: `packed_reg` from the package (`bit [3:0][2:1]`, 8 bits). Not a parameter.

Ports:
- clk         in   1                 clock, rising edge
- rst         in   1                 synchronous, active-high reset
- load_valid  in   1                 load request
- load_ready  out  1                 block can accept a load
- load_rev    in   1                 sampled at load; 1 = walk `$right`→`$left` in both dims
- load_data   in   packed_reg [L1:R1][L2:R2]   unpacked array to capture
- out_valid   out  1                 output beat valid
- out_ready   in   1                 downstream accepts beat
- out_data    out  packed_reg        current element
- out_idx1    out  32 (int)          declared index, dimension 1
- out_idx2    out  32 (int)          declared index, dimension 2
- out_first   out  1                 first beat of the walk
- out_last    out  1                 final beat of the walk
- busy        out  1                 walk in progress

Behaviour:
- **Sizes and steps**
  - N1 = |L1−R1|+1, N2 = |L2−R2|+1, total beats N = N1·N2 (35 at defaults).
  - Forward step per dimension is +1 if L≤R, else −1. Reverse walk negates it.
  - The step is derived from the bounds directly, not from `$increment`.
- **States**
  - IDLE: load_ready=1, out_valid=0, busy=0.
  - STREAM: load_ready=0, out_valid=1, busy=1.
- **Reset** (rst=1 at a clock edge, from any state, including mid-stream):
  - State → IDLE.
  - out_valid=0, out_first=0, out_last=0, busy=0.
  - out_idx1=L1, out_idx2=L2, out_data=0.
  - The array buffer is not cleared.
- **IDLE → STREAM** on load_valid && load_ready:
  - Capture load_data and load_rev.
  - idx1/idx2 := L1/L2, or R1/R2 if load_rev.
  - The first beat is valid on the next cycle, so load-to-first-beat latency is 1 clock.
- **Output beat**
  - out_data = buf[out_idx1][out_idx2], registered (no combinational path from load_data).
  - out_first=1 only on the first beat.
  - out_last=1 when both indices equal their terminal bounds (R, or L when reversed).
- **Handshake**
  - A beat completes on out_valid && out_ready.
  - While out_ready=0, all out_* signals hold stable.
  - out_valid never drops without a completed handshake, except on reset.
- **Advance on a completed non-last beat**
  - If idx2 is not terminal: idx2 += step2.
  - Else: idx2 := start2, idx1 += step1 (inner wraps, outer advances).
- **Completing the last beat**
  - STREAM → IDLE; out_valid=0 on the next cycle.
  - load_ready returns to 1 that same next cycle; no same-cycle reload overlap.
- **Other boundary cases**
  - load_valid while busy: ignored, no capture.
  - N1=1 or N2=1: degenerate dimensions are legal.
  - L=R in both dims: a single beat with out_first=out_last=1.
- **Width rules**
  - Index arithmetic is 32-bit signed.
  - Bounds may be negative or descending.

Decomposition:
- **Package `dims_pkg`**
  - `typedef bit [3:0][2:1] packed_reg`.
  - `typedef enum {IDLE, STREAM}` walker state.
  - Function `dim_size(l, r)` and function `dim_step(l, r)`.
- **Sub-module `array_dim_counter`** (instantiated twice, once per dimension):
  - Parameters L, R.
  - Inputs: rev, start, advance.
  - Outputs: idx, at_end.
  - Holds one dimension's index with wrap to its start bound.

Test Plan:
- **Forward walk.** Defaults; load_data[i][j] = {i[3:0], j[3:0]}, out_ready=1.
  - 35 beats on consecutive cycles.
  - Beat 1: (1,2) 0x12, out_first=1.
  - Beat 7: (1,8) 0x18.
  - Beat 8: (2,2) 0x22.
  - Beat 35: (5,8) 0x58, out_last=1.
  - load_ready=1 the cycle after beat 35.
- **Reverse walk.** Same data, load_rev=1.
  - Beat 1: (5,8) 0x58.
  - Beat 2: (5,7) 0x57.
  - Beat 8: (4,8) 0x48.
  - Beat 35: (1,2) 0x12, out_last=1.
- **Backpressure.** out_ready=0 for 3 cycles on beat 10.
  - (2,4) 0x24 holds stable for all 3 cycles.
  - Beat 11: (2,5) 0x25 follows after the handshake.
  - Total beats still 35.
- **Reset mid-stream.** Assert rst after beat 20.
  - Next cycle: out_valid=0, busy=0, load_ready=1.
  - A new load restarts at (1,2).
- **Load while busy.** Pulse load_valid with different data during beat 5.
  - Stream continues unchanged with the original data.
  - No second capture.
- **Descending bounds.** L1=4, R1=2, L2=0, R2=1.
  - 6 beats in order (4,0), (4,1), (3,0), (3,1), (2,0), (2,1).
  - out_last=1 on (2,1).
